// File: rtl/usb_rx_bit_decoder.sv
// USB receive front-end: NRZI decode, SYNC hunt, bit unstuffing, byte assembly,
// EOP detection and error recovery, driven by a per-bit sample strobe.
//   state      | meaning
//   S_IDLE     | hunting for SYNC
//   S_DATA     | receiving packet bits
//   S_EOP_SE0  | SE0 seen, waiting for J to close the packet
//   S_ERR_WAIT | error recovery, waiting for SE0+J or an idle J run
module usb_rx_bit_decoder #(
    parameter int MAX_BYTES    = 1026,
    parameter int IDLE_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       bit_strobe,
    input  logic       dp,
    input  logic       dm,
    output logic [7:0] rx_data,
    output logic       RXValid,
    output logic       RXActive,
    output logic       RXError,
    output logic       SYNC_Detected,
    output logic       EOP_Detected
);

    localparam int BCW = $clog2(MAX_BYTES + 1);
    localparam int TCW = $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_EOP_SE0, S_ERR_WAIT} state_t;

    state_t           state_q, state_d;
    logic             prev_j_q, prev_j_d;
    logic             last_se0_q, last_se0_d;
    logic [6:0]       shift_q, shift_d;
    logic [2:0]       ones_q, ones_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [BCW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [1:0]       se0_cnt_q, se0_cnt_d;
    logic [TCW-1:0]   j_cnt_q, j_cnt_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             valid_q, valid_d;
    logic             active_q, active_d;
    logic             error_q, error_d;
    logic             sync_q, sync_d;
    logic             eop_q, eop_d;

    logic       line_j, line_k, line_se0, line_jk, dec_bit;
    logic [7:0] shift_in;
    logic       sync_hit, byte_done, err_hit, eop_hit, exit_hit;

    assign line_j   = dp & ~dm;
    assign line_k   = ~dp & dm;
    assign line_se0 = ~dp & ~dm;
    assign line_jk  = line_j | line_k;
    assign dec_bit  = (line_j == prev_j_q);
    // shift_q holds the previous seven decoded bits; the newest enters at the MSB
    assign shift_in = {dec_bit, shift_q};

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            prev_j_q   <= 1'b1;
            last_se0_q <= 1'b0;
            shift_q    <= 7'h7F;
            ones_q     <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            se0_cnt_q  <= '0;
            j_cnt_q    <= '0;
            rx_data_q  <= '0;
            valid_q    <= 1'b0;
            active_q   <= 1'b0;
            error_q    <= 1'b0;
            sync_q     <= 1'b0;
            eop_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_j_q   <= prev_j_d;
            last_se0_q <= last_se0_d;
            shift_q    <= shift_d;
            ones_q     <= ones_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            se0_cnt_q  <= se0_cnt_d;
            j_cnt_q    <= j_cnt_d;
            rx_data_q  <= rx_data_d;
            valid_q    <= valid_d;
            active_q   <= active_d;
            error_q    <= error_d;
            sync_q     <= sync_d;
            eop_q      <= eop_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        prev_j_d   = prev_j_q;
        last_se0_d = last_se0_q;
        shift_d    = shift_q;
        ones_d     = ones_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        se0_cnt_d  = se0_cnt_q;
        j_cnt_d    = j_cnt_q;
        sync_hit   = 1'b0;
        byte_done  = 1'b0;
        err_hit    = 1'b0;
        eop_hit    = 1'b0;
        exit_hit   = 1'b0;
        if (bit_strobe) begin
            if (line_jk) prev_j_d = line_j;
            last_se0_d = line_se0;
            unique case (state_q)
                S_IDLE: begin
                    if (line_jk) begin
                        shift_d = shift_in[7:1];
                        if (shift_in == 8'h80) begin
                            sync_hit   = 1'b1;
                            state_d    = S_DATA;
                            ones_d     = 3'd1;
                            bit_cnt_d  = '0;
                            byte_cnt_d = '0;
                        end
                    end else begin
                        // all-ones flush: SYNC then needs eight fresh decoded bits
                        shift_d = 7'h7F;
                    end
                end
                S_DATA: begin
                    if (line_jk) begin
                        if (ones_q == 3'd6) begin
                            if (dec_bit) err_hit = 1'b1;
                            else         ones_d  = '0;
                        end else if (byte_cnt_q == BCW'(MAX_BYTES)) begin
                            err_hit = 1'b1;
                        end else begin
                            shift_d   = shift_in[7:1];
                            ones_d    = dec_bit ? ones_q + 3'd1 : 3'd0;
                            bit_cnt_d = bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                byte_done  = 1'b1;
                                byte_cnt_d = byte_cnt_q + BCW'(1);
                            end
                        end
                    end else if (line_se0) begin
                        state_d   = S_EOP_SE0;
                        se0_cnt_d = 2'd1;
                    end else begin
                        err_hit = 1'b1;
                    end
                end
                S_EOP_SE0: begin
                    if (line_se0) begin
                        se0_cnt_d = se0_cnt_q + 2'd1;
                        if (se0_cnt_q == 2'd2) err_hit = 1'b1;
                    end else if (line_j) begin
                        eop_hit = 1'b1;
                    end else begin
                        err_hit = 1'b1;
                    end
                end
                S_ERR_WAIT: begin
                    if (line_j) begin
                        if (last_se0_q || j_cnt_q == TCW'(IDLE_TIMEOUT - 1)) exit_hit = 1'b1;
                        else j_cnt_d = j_cnt_q + TCW'(1);
                    end else begin
                        j_cnt_d = '0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
            if (err_hit) begin
                state_d = S_ERR_WAIT;
                j_cnt_d = '0;
            end
            if (eop_hit || exit_hit) begin
                state_d = S_IDLE;
                shift_d = 7'h7F;
            end
        end
    end

    always_comb begin
        rx_data_d = byte_done ? shift_in : rx_data_q;
        valid_d   = byte_done;
        sync_d    = sync_hit;
        eop_d     = eop_hit;
        active_d  = (state_d != S_IDLE);
        // a partial byte at EOP flags RXError for that one cycle only
        error_d   = (state_d == S_ERR_WAIT) | (eop_hit & (bit_cnt_q != 3'd0));
    end

    assign rx_data       = rx_data_q;
    assign RXValid       = valid_q;
    assign RXActive      = active_q;
    assign RXError       = error_q;
    assign SYNC_Detected = sync_q;
    assign EOP_Detected  = eop_q;

endmodule

// File: tb/tb_usb_rx_bit_decoder.sv
// Bench for usb_rx_bit_decoder: two instances (default and MAX_BYTES=2) driven by
// the same line, each compared every cycle against a queue-based packet model.
module tb_usb_rx_bit_decoder;

    localparam int IDLE_TO = 8;
    localparam logic [1:0] L_SE0 = 2'b00, L_K = 2'b01, L_J = 2'b10, L_SE1 = 2'b11;
    localparam int MI = 0, MD = 1, ME = 2, MW = 3;

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic       bit_strobe = 1'b0;
    logic       dp = 1'b1;
    logic       dm = 1'b0;
    logic [7:0] rx_data_o [2];
    logic       val_o [2], act_o [2], err_o [2], sync_o [2], eop_o [2];

    usb_rx_bit_decoder dut0 (
        .clk(clk), .Reset(Reset), .bit_strobe(bit_strobe), .dp(dp), .dm(dm),
        .rx_data(rx_data_o[0]), .RXValid(val_o[0]), .RXActive(act_o[0]),
        .RXError(err_o[0]), .SYNC_Detected(sync_o[0]), .EOP_Detected(eop_o[0])
    );

    usb_rx_bit_decoder #(.MAX_BYTES(2)) dut1 (
        .clk(clk), .Reset(Reset), .bit_strobe(bit_strobe), .dp(dp), .dm(dm),
        .rx_data(rx_data_o[1]), .RXValid(val_o[1]), .RXActive(act_o[1]),
        .RXError(err_o[1]), .SYNC_Detected(sync_o[1]), .EOP_Detected(eop_o[1])
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // reference model state
    int         m_max [2];
    int         m_st [2], m_run1 [2], m_nbytes [2], m_nse0 [2], m_njs [2];
    bit         m_prev_j [2], m_last_se0 [2];
    bit         m_hist [2][$];
    bit         m_cur [2][$];
    bit         e_sync [2], e_eop [2], e_act [2], e_err [2], e_val [2];
    logic [7:0] e_data [2];

    // observed-event counters for the directed scenarios
    int         c_val [2], c_sync [2], c_eop [2], c_errcyc [2];
    logic [7:0] c_data [2];

    bit tx_j;
    int tx_ones;

    function automatic void m_reset(int id);
        m_st[id] = MI; m_run1[id] = 0; m_nbytes[id] = 0; m_nse0[id] = 0; m_njs[id] = 0;
        m_prev_j[id] = 1'b1; m_last_se0[id] = 1'b0;
        m_hist[id].delete(); m_cur[id].delete();
        e_sync[id] = 0; e_eop[id] = 0; e_act[id] = 0; e_err[id] = 0; e_val[id] = 0;
        e_data[id] = 8'h00;
    endfunction

    function automatic void m_to_err(int id);
        m_st[id] = MW; e_err[id] = 1'b1; m_njs[id] = 0;
    endfunction

    function automatic void m_quiet(int id);
        e_sync[id] = 0; e_eop[id] = 0; e_val[id] = 0;
        if (m_st[id] == MI) e_err[id] = 0;
    endfunction

    function automatic void m_step(int id, logic [1:0] l);
        bit isj, isk, s0, b, hit;
        isj = (l == L_J); isk = (l == L_K); s0 = (l == L_SE0);
        b = (isj == m_prev_j[id]);
        m_quiet(id);
        case (m_st[id])
            MI: begin
                if (isj || isk) begin
                    m_hist[id].push_back(b);
                    if (m_hist[id].size() > 8) void'(m_hist[id].pop_front());
                    hit = (m_hist[id].size() == 8) && m_hist[id][7];
                    for (int i = 0; i < 7; i++) if (m_hist[id].size() == 8 && m_hist[id][i]) hit = 0;
                    if (hit) begin
                        m_st[id] = MD; e_sync[id] = 1; e_act[id] = 1;
                        m_run1[id] = 1; m_cur[id].delete(); m_nbytes[id] = 0;
                    end
                end else m_hist[id].delete();
            end
            MD: begin
                if (isj || isk) begin
                    if (m_run1[id] == 6) begin
                        if (b) m_to_err(id);
                        else m_run1[id] = 0;
                    end else if (m_nbytes[id] == m_max[id]) m_to_err(id);
                    else begin
                        m_cur[id].push_back(b);
                        m_run1[id] = b ? m_run1[id] + 1 : 0;
                        if (m_cur[id].size() == 8) begin
                            for (int i = 0; i < 8; i++) e_data[id][i] = m_cur[id][i];
                            e_val[id] = 1; m_cur[id].delete(); m_nbytes[id]++;
                        end
                    end
                end else if (s0) begin
                    m_st[id] = ME; m_nse0[id] = 1;
                end else m_to_err(id);
            end
            ME: begin
                if (s0) begin
                    m_nse0[id]++;
                    if (m_nse0[id] == 3) m_to_err(id);
                end else if (isj) begin
                    e_eop[id] = 1; e_act[id] = 0; m_st[id] = MI; m_hist[id].delete();
                    e_err[id] = (m_cur[id].size() != 0);
                end else m_to_err(id);
            end
            default: begin
                if (isj) begin
                    m_njs[id]++;
                    if (m_last_se0[id] || m_njs[id] == IDLE_TO) begin
                        m_st[id] = MI; e_act[id] = 0; e_err[id] = 0; m_hist[id].delete();
                    end
                end else m_njs[id] = 0;
            end
        endcase
        if (isj || isk) m_prev_j[id] = isj;
        m_last_se0[id] = s0;
    endfunction

    task automatic check_all();
        for (int id = 0; id < 2; id++) begin
            chk($sformatf("dut%0d {data,sync,eop,act,err,val}", id),
                {19'd0, rx_data_o[id], sync_o[id], eop_o[id], act_o[id], err_o[id], val_o[id]},
                {19'd0, e_data[id], e_sync[id], e_eop[id], e_act[id], e_err[id], e_val[id]});
            if (val_o[id]) begin c_val[id]++; c_data[id] = rx_data_o[id]; end
            if (sync_o[id]) c_sync[id]++;
            if (eop_o[id]) c_eop[id]++;
            if (err_o[id]) c_errcyc[id]++;
        end
    endtask

    task automatic clr_counts();
        for (int id = 0; id < 2; id++) begin
            c_val[id] = 0; c_sync[id] = 0; c_eop[id] = 0; c_errcyc[id] = 0; c_data[id] = 8'h00;
        end
    endtask

    // called at a negedge; returns at a negedge after all checks
    task automatic strobe_line(input logic [1:0] l, input int gap);
        {dp, dm} = l;
        bit_strobe = 1'b1;
        @(posedge clk);
        m_step(0, l); m_step(1, l);
        @(negedge clk);
        bit_strobe = 1'b0;
        check_all();
        repeat (gap) begin
            @(posedge clk);
            m_quiet(0); m_quiet(1);
            @(negedge clk);
            check_all();
        end
    endtask

    task automatic send_line(input logic [1:0] l);
        if (l == L_J) tx_j = 1'b1;
        if (l == L_K) tx_j = 1'b0;
        strobe_line(l, $urandom_range(1, 2));
    endtask

    task automatic send_bit(input bit b);
        if (!b) tx_j = !tx_j;
        send_line(tx_j ? L_J : L_K);
    endtask

    task automatic send_dbit(input bit b, input bit stuff_en);
        send_bit(b);
        tx_ones = b ? tx_ones + 1 : 0;
        if (stuff_en && tx_ones == 6) begin
            send_bit(1'b0);
            tx_ones = 0;
        end
    endtask

    task automatic send_sync();
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        send_bit(1'b1);
        tx_ones = 1;
    endtask

    task automatic send_byte(input logic [7:0] v, input bit stuff_en);
        for (int i = 0; i < 8; i++) send_dbit(v[i], stuff_en);
    endtask

    task automatic send_eop();
        send_line(L_SE0);
        send_line(L_SE0);
        send_line(L_J);
    endtask

    task automatic do_reset();
        #2 Reset = 1'b1;
        #1;
        for (int id = 0; id < 2; id++)
            chk($sformatf("dut%0d async reset outputs", id),
                {19'd0, rx_data_o[id], sync_o[id], eop_o[id], act_o[id], err_o[id], val_o[id]}, 32'd0);
        m_reset(0); m_reset(1);
        tx_j = 1'b1; tx_ones = 0;
        @(posedge clk);
        @(negedge clk);
        Reset = 1'b0;
        check_all();
    endtask

    task automatic rand_packet();
        int nb, mode;
        logic [7:0] v;
        repeat ($urandom_range(1, 3)) send_line(L_J);
        send_sync();
        nb = $urandom_range(0, 4);
        for (int i = 0; i < nb; i++) begin
            v = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
            for (int k = 0; k < 8; k++) begin
                if ($urandom_range(0, 59) == 0) send_line(2'($urandom));
                else send_dbit(v[k], $urandom_range(0, 19) != 0);
            end
        end
        mode = $urandom_range(0, 4);
        case (mode)
            0: send_eop();
            1: begin
                repeat ($urandom_range(1, 7)) send_dbit(1'($urandom), 1'b1);
                send_eop();
            end
            2: send_line(L_SE1);
            3: begin
                repeat (3) send_line(L_SE0);
                send_line(L_J);
            end
            default: begin
                send_line(L_SE0);
                send_line(L_K);
            end
        endcase
        repeat (IDLE_TO + 1 + $urandom_range(0, 3)) send_line(L_J);
    endtask

    initial begin
        logic [7:0] v;
        m_max[0] = 1026; m_max[1] = 2;
        m_reset(0); m_reset(1);
        tx_j = 1'b1; tx_ones = 0;
        @(negedge clk);
        for (int id = 0; id < 2; id++)
            chk($sformatf("dut%0d reset outputs", id),
                {19'd0, rx_data_o[id], sync_o[id], eop_o[id], act_o[id], err_o[id], val_o[id]}, 32'd0);
        @(negedge clk);
        Reset = 1'b0;
        check_all();

        // clean packet carrying 0xA5
        clr_counts();
        repeat (3) send_line(L_J);
        send_sync();
        send_byte(8'hA5, 1'b1);
        send_eop();
        chk("t1 sync pulses", c_sync[0], 1);
        chk("t1 valid pulses", c_val[0], 1);
        chk("t1 data", c_data[0], 8'hA5);
        chk("t1 eop pulses", c_eop[0], 1);
        chk("t1 error cycles", c_errcyc[0], 0);
        chk("t1 active at end", act_o[0], 0);

        // 0xFF with its stuff bit
        clr_counts();
        repeat (2) send_line(L_J);
        send_sync();
        send_byte(8'hFF, 1'b1);
        send_eop();
        chk("t2 valid pulses", c_val[0], 1);
        chk("t2 data", c_data[0], 8'hFF);
        chk("t2 error cycles", c_errcyc[0], 0);

        // 0xFF with the stuff bit missing, recovery by idle timeout
        clr_counts();
        repeat (2) send_line(L_J);
        send_sync();
        repeat (6) send_dbit(1'b1, 1'b0);
        chk("t2b error", err_o[0], 1);
        chk("t2b active", act_o[0], 1);
        repeat (IDLE_TO - 1) send_line(L_J);
        chk("t2b active before timeout", act_o[0], 1);
        chk("t2b error before timeout", err_o[0], 1);
        send_line(L_J);
        chk("t2b active after timeout", act_o[0], 0);
        chk("t2b error after timeout", err_o[0], 0);
        chk("t2b eop pulses", c_eop[0], 0);

        // 12 data bits then EOP: one byte plus a partial-byte error pulse
        clr_counts();
        repeat (2) send_line(L_J);
        send_sync();
        repeat (12) send_dbit(1'($urandom), 1'b1);
        send_eop();
        chk("t3 valid pulses", c_val[0], 1);
        chk("t3 eop pulses", c_eop[0], 1);
        chk("t3 error cycles", c_errcyc[0], 1);
        chk("t3 active at end", act_o[0], 0);

        // SE1 mid-packet, recovery by SE0 then J
        clr_counts();
        repeat (2) send_line(L_J);
        send_sync();
        repeat (3) send_dbit(1'($urandom), 1'b1);
        send_line(L_SE1);
        chk("t4 error after SE1", err_o[0], 1);
        chk("t4 active after SE1", act_o[0], 1);
        send_line(L_SE0);
        chk("t4 error after SE0", err_o[0], 1);
        send_line(L_J);
        chk("t4 active after J", act_o[0], 0);
        chk("t4 error after J", err_o[0], 0);
        chk("t4 eop pulses", c_eop[0], 0);

        // three bytes: babble on the MAX_BYTES=2 instance
        clr_counts();
        repeat (2) send_line(L_J);
        send_sync();
        for (int i = 0; i < 3; i++) begin
            v = 8'($urandom);
            send_byte(v, 1'b1);
            if (i == 1) chk("t5 dut1 no error after byte 2", err_o[1], 0);
        end
        send_eop();
        chk("t5 dut1 valid pulses", c_val[1], 2);
        chk("t5 dut0 valid pulses", c_val[0], 3);
        chk("t5 dut1 error seen", c_errcyc[1] != 0, 1);
        chk("t5 dut1 eop pulses", c_eop[1], 0);
        chk("t5 dut1 active at end", act_o[1], 0);

        // reset mid-packet, then a clean 0x3C packet
        clr_counts();
        repeat (2) send_line(L_J);
        send_sync();
        repeat (4) begin
            v = 8'($urandom);
            send_byte(v, 1'b1);
        end
        repeat (3) send_dbit(1'($urandom), 1'b1);
        chk("t6 active before reset", act_o[0], 1);
        do_reset();
        clr_counts();
        repeat (3) send_line(L_J);
        send_sync();
        send_byte(8'h3C, 1'b1);
        send_eop();
        chk("t6 dut0 valid pulses", c_val[0], 1);
        chk("t6 dut0 data", c_data[0], 8'h3C);
        chk("t6 dut1 valid pulses", c_val[1], 1);
        chk("t6 dut1 data", c_data[1], 8'h3C);

        repeat (150) rand_packet();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
